// File: rtl/int2_unpacker.sv
// Unpacks a pair of 32-bit signed ints into two sequential integer elements.
// Latency: pair accepted at edge N -> first element valid in cycle N+1; one element per cycle at full rate.
// Backpressure: output held stable while not taken; one pending pair buffered, then pair_in_notify drops.
module int2_unpacker #(
  parameter bit SWAP  = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0][31:0]     pair_in,
  input  logic                 pair_in_sync,
  output logic                 pair_in_notify,
  output logic [31:0]          elem_out,
  input  logic                 elem_out_sync,
  output logic                 elem_out_notify,
  output logic [CNT_W-1:0]     pairs_done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND_F = 2'd1;
  localparam logic [1:0] ST_SEND_S = 2'd2;

  // Element order within a pair: F is sent first, S second.
  localparam logic IDX_F = SWAP;
  localparam logic IDX_S = !SWAP;

  logic [1:0]           r_state,  w_state;
  logic [1:0][31:0]     r_cur,    w_cur;
  logic [1:0][31:0]     r_pend,   w_pend;
  logic                 r_pend_v, w_pend_v;
  logic [31:0]          r_elem,   w_elem;
  logic                 r_out_v,  w_out_v;
  logic                 r_in_rdy;
  logic [CNT_W-1:0]     r_cnt,    w_cnt;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = pair_in_sync && r_in_rdy;
  assign w_out_xfer = elem_out_sync && r_out_v;

  // Next-state logic: current pair emission, pending-pair buffering and the completed-pair count.
  always_comb begin
    w_state  = r_state;
    w_cur    = r_cur;
    w_pend   = r_pend;
    w_pend_v = r_pend_v;
    w_elem   = r_elem;
    w_out_v  = r_out_v;
    w_cnt    = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_out_v = 1'b0;
        if (w_in_xfer) begin
          w_cur   = pair_in;
          w_elem  = pair_in[IDX_F];
          w_out_v = 1'b1;
          w_state = ST_SEND_F;
        end
      end
      ST_SEND_F: begin
        if (w_out_xfer) begin
          w_elem  = r_cur[IDX_S];
          w_state = ST_SEND_S;
        end
        if (w_in_xfer) begin
          w_pend   = pair_in;
          w_pend_v = 1'b1;
        end
      end
      ST_SEND_S: begin
        if (w_out_xfer) begin
          w_cnt = r_cnt + CNT_W'(1);
          if (r_pend_v) begin
            // Input is closed while pend is full, so no new pair can collide here.
            w_cur    = r_pend;
            w_elem   = r_pend[IDX_F];
            w_pend_v = 1'b0;
            w_state  = ST_SEND_F;
          end else if (w_in_xfer) begin
            // Pair arriving on the last element's edge goes straight to cur: no bubble.
            w_cur   = pair_in;
            w_elem  = pair_in[IDX_F];
            w_state = ST_SEND_F;
          end else begin
            w_out_v = 1'b0;
            w_state = ST_IDLE;
          end
        end else if (w_in_xfer) begin
          w_pend   = pair_in;
          w_pend_v = 1'b1;
        end
      end
      default: begin
        w_out_v  = 1'b0;
        w_pend_v = 1'b0;
        w_state  = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any pair in flight so nothing partial follows release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cur    <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_elem   <= '0;
      r_out_v  <= 1'b0;
      r_in_rdy <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state;
      r_cur    <= w_cur;
      r_pend   <= w_pend;
      r_pend_v <= w_pend_v;
      r_elem   <= w_elem;
      r_out_v  <= w_out_v;
      r_in_rdy <= !w_pend_v;
      r_cnt    <= w_cnt;
    end
  end

  assign pair_in_notify  = r_in_rdy;
  assign elem_out        = r_elem;
  assign elem_out_notify = r_out_v;
  assign pairs_done      = r_cnt;

endmodule

// File: tb/tb_int2_unpacker.sv
// Bench for int2_unpacker: dut0 (SWAP=0, CNT_W=16) and dut1 (SWAP=1, CNT_W=2).
// Expected elements are queued on pair acceptance and compared when the DUT emits.
module tb_int2_unpacker;

  typedef struct {
    int a;
    int b;
    int e0;
    int e1;
    int cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst0, rst1;
  logic [1:0][31:0] pin0, pin1;
  logic            isync0, isync1, osync0, osync1;
  wire             inot0, inot1, eon0, eon1;
  wire [31:0]      eo0, eo1;
  wire [15:0]      pd0;
  wire [1:0]       pd1;

  int errors = 0;
  int checks = 0;
  int q0[$];
  int q1[$];

  int2_unpacker #(.SWAP(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst0), .pair_in(pin0), .pair_in_sync(isync0),
    .pair_in_notify(inot0), .elem_out(eo0), .elem_out_sync(osync0),
    .elem_out_notify(eon0), .pairs_done(pd0));

  int2_unpacker #(.SWAP(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst1), .pair_in(pin1), .pair_in_sync(isync1),
    .pair_in_notify(inot1), .elem_out(eo1), .elem_out_sync(osync1),
    .elem_out_notify(eon1), .pairs_done(pd1));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input int d, input int ev);
    if (d == 0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected element: got %0d expected none", ev);
      end else chk("dut0 elem", ev, q0.pop_front());
    end else begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected element: got %0d expected none", ev);
      end else chk("dut1 elem", ev, q1.pop_front());
    end
  endtask

  // One clock cycle: drive at negedge, sample just after, let the rising edge happen.
  task automatic step(input int d, input logic iv, input int a, input int b,
                      input int e0, input int e1, input logic rdy,
                      output logic acc, output logic ov, output int ev, output logic inr);
    @(negedge clk);
    if (d == 0) begin
      pin0[0] = a; pin0[1] = b; isync0 = iv; osync0 = rdy;
    end else begin
      pin1[0] = a; pin1[1] = b; isync1 = iv; osync1 = rdy;
    end
    #1;
    acc = 1'b0;
    if (d == 0) begin ov = eon0; ev = $signed(eo0); inr = inot0; end
    else        begin ov = eon1; ev = $signed(eo1); inr = inot1; end
    if (ov && rdy) pop_cmp(d, ev);
    if (inr && iv) begin
      acc = 1'b1;
      if (d == 0) begin q0.push_back(e0); q0.push_back(e1); end
      else        begin q1.push_back(e0); q1.push_back(e1); end
    end
    @(posedge clk);
  endtask

  task automatic offer(input int d, input int a, input int b, input int e0, input int e1,
                       input logic rdy);
    logic acc, ov, inr;
    int ev;
    acc = 1'b0;
    for (int i = 0; i < 30 && !acc; i++) step(d, 1'b1, a, b, e0, e1, rdy, acc, ov, ev, inr);
    if (!acc) chk("offer accepted", 0, 1);
  endtask

  task automatic drain(input int d, output int pops);
    logic acc, ov, inr, done;
    int ev;
    pops = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(d, 1'b0, 0, 0, 0, 0, 1'b1, acc, ov, ev, inr);
      if (ov) pops++;
      if (!ov && ((d == 0) ? q0.size() : q1.size()) == 0) done = 1'b1;
    end
    if (!done) chk("drain finished in budget", 0, 1);
  endtask

  // Park both DUTs with no handshakes and sample just after the falling edge.
  task automatic settle();
    @(negedge clk);
    isync0 = 1'b0; osync0 = 1'b0; isync1 = 1'b0; osync1 = 1'b0;
    #1;
  endtask

  initial begin
    vec_t v3[3];
    vec_t vw[5];
    logic acc, ov, inr;
    int ev, pops, idx, stepn, first_pop, last_pop, pd_before;

    v3[0] = '{a: 1, b: 2, e0: 1, e1: 2, cnt: 0};
    v3[1] = '{a: 3, b: 4, e0: 3, e1: 4, cnt: 0};
    v3[2] = '{a: 5, b: 6, e0: 5, e1: 6, cnt: 3};
    vw[0] = '{a: 1,   b: 2,   e0: 2,   e1: 1,   cnt: 1};
    vw[1] = '{a: 10,  b: 20,  e0: 20,  e1: 10,  cnt: 2};
    vw[2] = '{a: -3,  b: 4,   e0: 4,   e1: -3,  cnt: 3};
    vw[3] = '{a: 7,   b: -8,  e0: -8,  e1: 7,   cnt: 0};
    vw[4] = '{a: 100, b: 200, e0: 200, e1: 100, cnt: 1};

    rst0 = 1'b1; rst1 = 1'b1;
    pin0 = '0; pin1 = '0;
    isync0 = 1'b0; isync1 = 1'b0; osync0 = 1'b0; osync1 = 1'b0;
    repeat (2) @(posedge clk);
    settle();
    chk("reset dut0 elem_out", $signed(eo0), 0);
    chk("reset dut0 elem_out_notify", int'(eon0), 0);
    chk("reset dut0 pair_in_notify", int'(inot0), 1);
    chk("reset dut0 pairs_done", int'(pd0), 0);
    chk("reset dut1 elem_out_notify", int'(eon1), 0);
    chk("reset dut1 pair_in_notify", int'(inot1), 1);
    rst0 = 1'b0; rst1 = 1'b0;

    // Single pair, latency and completion.
    step(0, 1'b1, 5, -7, 5, -7, 1'b1, acc, ov, ev, inr);
    chk("t1 pair accepted", int'(acc), 1);
    step(0, 1'b0, 0, 0, 0, 0, 1'b1, acc, ov, ev, inr);
    chk("t1 first elem valid N+1", int'(ov), 1);
    step(0, 1'b0, 0, 0, 0, 0, 1'b1, acc, ov, ev, inr);
    chk("t1 second elem valid N+2", int'(ov), 1);
    step(0, 1'b0, 0, 0, 0, 0, 1'b1, acc, ov, ev, inr);
    chk("t1 notify low after pair", int'(ov), 0);
    settle();
    chk("t1 pairs_done", int'(pd0), 1);

    // Back-to-back pairs from the table at full rate: no bubble after the first element.
    pd_before = int'(pd0);
    idx = 0; pops = 0; first_pop = -1; last_pop = -1; stepn = 0;
    for (int i = 0; i < 30; i++) begin
      if (idx < 3)
        step(0, 1'b1, v3[idx].a, v3[idx].b, v3[idx].e0, v3[idx].e1, 1'b1, acc, ov, ev, inr);
      else
        step(0, 1'b0, 0, 0, 0, 0, 1'b1, acc, ov, ev, inr);
      if (acc) idx++;
      if (ov) begin
        pops++;
        if (first_pop < 0) first_pop = stepn;
        last_pop = stepn;
      end
      stepn++;
      if (idx == 3 && q0.size() == 0 && !ov && pops > 0) break;
    end
    chk("t3 element count", pops, 6);
    chk("t3 consecutive span", last_pop - first_pop, 5);
    settle();
    chk("t3 pairs_done delta", int'(pd0) - pd_before, v3[2].cnt);

    // Backpressure: two pairs held, output frozen, input closed.
    offer(0, 9, 8, 9, 8, 1'b0);
    offer(0, 7, 6, 7, 6, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1'b0, 0, 0, 0, 0, 1'b0, acc, ov, ev, inr);
      chk("t4 held elem", ev, 9);
      chk("t4 held notify", int'(ov), 1);
      chk("t4 input closed", int'(inr), 0);
    end
    drain(0, pops);
    chk("t4 drained elements", pops, 4);

    // Reset while in SEND_S with a pending pair.
    offer(0, 1, 2, 1, 2, 1'b0);
    offer(0, 3, 4, 3, 4, 1'b0);
    step(0, 1'b0, 0, 0, 0, 0, 1'b1, acc, ov, ev, inr);
    settle();
    rst0 = 1'b1;
    #1;
    chk("t6 reset elem_out", $signed(eo0), 0);
    chk("t6 reset elem_out_notify", int'(eon0), 0);
    chk("t6 reset pair_in_notify", int'(inot0), 1);
    chk("t6 reset pairs_done", int'(pd0), 0);
    q0.delete();
    settle();
    rst0 = 1'b0;
    offer(0, 11, 12, 11, 12, 1'b1);
    drain(0, pops);
    chk("t6 elements after reset", pops, 2);

    // SWAP=1 ordering and 2-bit counter wrap, one pair at a time.
    for (int i = 0; i < 5; i++) begin
      offer(1, vw[i].a, vw[i].b, vw[i].e0, vw[i].e1, 1'b1);
      drain(1, pops);
      chk("t5 elements per pair", pops, 2);
      settle();
      chk("t5 pairs_done wrap", int'(pd1), vw[i].cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
